// File: rtl/jtframe_objdraw.sv
// jtframe_objdraw: object line-draw engine with an integrated double line buffer.
// It fetches 8-pixel 4bpp ROM words and writes opaque pixels into the back bank.
// In parallel it streams the front bank to the palette, erasing each pixel it reads.
module jtframe_objdraw #(
  parameter int         CW    = 10,
  parameter int         PW    = 4,
  parameter int         HW    = 9,
  parameter int         WIDE  = 0,
  parameter logic [3:0] ALPHA = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic [HW-1:0] hdump,
  input  logic          draw,
  output logic          busy,
  input  logic [CW-1:0] code,
  input  logic [HW-1:0] xpos,
  input  logic [3:0]    ysub,
  input  logic [PW-1:0] pal,
  input  logic          hflip,
  input  logic          vflip,
  output logic [CW+4:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [31:0]   rom_data,
  output logic [PW+3:0] pxl
);

  localparam int DEPTH = 1 << HW;

  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

  state_t        st, st_nx;
  logic          sel, lhbl_l, swap;
  logic          guard, second;
  logic [2:0]    cnt;
  logic [31:0]   data;
  logic [HW-1:0] xpos_l;
  logic [PW-1:0] pal_l;
  logic          hflip_l;
  logic          accept, got, next_word, wr;
  logic [3:0]    pen;
  logic [HW-1:0] wr_addr;
  logic          er_pend, er_bank;
  logic [HW-1:0] er_addr;
  logic [PW+3:0] bank0 [DEPTH];
  logic [PW+3:0] bank1 [DEPTH];

  assign swap    = lhbl_l & ~LHBL;
  assign pen     = hflip_l ? data[3:0] : data[31:28];
  assign wr_addr = xpos_l + HW'({second, cnt});
  assign busy    = st != IDLE;
  assign rom_cs  = st == FETCH;

  // State register; a reset drops any object in progress.
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  // Next-state logic; a bank swap wins over everything and aborts the object.
  always_comb begin
    st_nx     = st;
    accept    = 1'b0;
    got       = 1'b0;
    next_word = 1'b0;
    wr        = 1'b0;
    if (swap) begin
      st_nx = IDLE;
    end else begin
      case (st)
        IDLE: begin
          if (draw) begin
            accept = 1'b1;
            st_nx  = FETCH;
          end
        end
        FETCH: begin
          if (!guard && rom_ok) begin
            got   = 1'b1;
            st_nx = DRAW;
          end
        end
        DRAW: begin
          wr = pen != ALPHA;
          if (cnt == 3'd7) begin
            if (WIDE != 0 && !second) begin
              next_word = 1'b1;
              st_nx     = FETCH;
            end else begin
              st_nx = IDLE;
            end
          end
        end
        default: st_nx = IDLE;
      endcase
    end
  end

  // Command latch, ROM addressing and the pixel shifter feeding the draw side.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      guard    <= 1'b0;
      second   <= 1'b0;
      cnt      <= 3'd0;
      data     <= 32'd0;
      xpos_l   <= '0;
      pal_l    <= '0;
      hflip_l  <= 1'b0;
    end else begin
      guard <= (st_nx == FETCH) && (st != FETCH);
      if (accept) begin
        rom_addr <= {code, ysub ^ {4{vflip}}, (WIDE != 0) ? hflip : 1'b0};
        xpos_l   <= xpos;
        pal_l    <= pal;
        hflip_l  <= hflip;
        second   <= 1'b0;
      end
      if (next_word) begin
        second      <= 1'b1;
        rom_addr[0] <= ~rom_addr[0];
      end
      if (got) begin
        data <= rom_data;
        cnt  <= 3'd0;
      end else if (st == DRAW) begin
        cnt  <= cnt + 3'd1;
        data <= hflip_l ? (data >> 4) : (data << 4);
      end
    end
  end

  // Bank 0 write port: read-side erase when it is the front bank, drawing otherwise.
  always_ff @(posedge clk) begin
    if (er_pend && !er_bank) bank0[er_addr] <= {{PW{1'b0}}, ALPHA};
    else if (wr && sel)      bank0[wr_addr] <= {pal_l, pen};
  end

  // Bank 1 write port: same arrangement with the roles of sel inverted.
  always_ff @(posedge clk) begin
    if (er_pend && er_bank) bank1[er_addr] <= {{PW{1'b0}}, ALPHA};
    else if (wr && !sel)    bank1[wr_addr] <= {pal_l, pen};
  end

  // Read side: bank swap on LHBL falling, pixel read and a deferred erase of that pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= 1'b0;
      lhbl_l  <= 1'b1;
      pxl     <= '0;
      er_pend <= 1'b0;
      er_bank <= 1'b0;
      er_addr <= '0;
    end else begin
      lhbl_l  <= LHBL;
      if (swap) sel <= ~sel;
      er_pend <= pxl_cen;
      if (pxl_cen) begin
        er_addr <= hdump;
        er_bank <= sel;
        pxl     <= sel ? bank1[hdump] : bank0[hdump];
      end
    end
  end

endmodule

// File: tb/tb_jtframe_objdraw.sv
// tb_jtframe_objdraw: directed checks of the object draw engine and its line buffer.
// Two instances share most inputs: dut is 8 px wide, dut_w is 16 px wide.
module tb_jtframe_objdraw;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, LHBL;
  logic [8:0]  hdump, xpos;
  logic        draw0, draw1, busy0, busy1;
  logic [9:0]  code;
  logic [3:0]  ysub, pal;
  logic        hflip, vflip, rom_ok;
  logic [14:0] rom_addr0, rom_addr1;
  logic        rom_cs0, rom_cs1;
  logic [31:0] rom_data0, rom_data1, w0, w1;
  logic [7:0]  pxl0, pxl1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         grp;
    logic       wide;
    logic [8:0] h;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t vec[$];

  // The wide instance sees a two-word ROM selected by the word bit of its address.
  assign rom_data1 = rom_addr1[0] ? w1 : w0;

  // Free-running system clock.
  always #5 clk = ~clk;

  jtframe_objdraw dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .draw(draw0), .busy(busy0), .code(code), .xpos(xpos), .ysub(ysub),
    .pal(pal), .hflip(hflip), .vflip(vflip), .rom_addr(rom_addr0),
    .rom_cs(rom_cs0), .rom_ok(rom_ok), .rom_data(rom_data0), .pxl(pxl0)
  );

  jtframe_objdraw #(.WIDE(1)) dut_w (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .LHBL(LHBL), .hdump(hdump),
    .draw(draw1), .busy(busy1), .code(code), .xpos(xpos), .ysub(ysub),
    .pal(pal), .hflip(hflip), .vflip(vflip), .rom_addr(rom_addr1),
    .rom_cs(rom_cs1), .rom_ok(rom_ok), .rom_data(rom_data1), .pxl(pxl1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input int g, input logic w, input int h, input int e);
    rd_vec_t v;
    v.grp  = g;
    v.wide = w;
    v.h    = 9'(h);
    v.exp  = 8'(e);
    vec.push_back(v);
  endfunction

  task automatic swap_banks;
    LHBL = 1'b0;
    tick;
    LHBL = 1'b1;
    tick;
  endtask

  task automatic read_px(input logic w, input logic [8:0] h, output logic [7:0] v);
    pxl_cen = 1'b1;
    hdump   = h;
    tick;
    pxl_cen = 1'b0;
    v = w ? pxl1 : pxl0;
  endtask

  task automatic erase_pass(output int bad0, output int bad1, output logic [7:0] at61);
    bad0 = 0;
    bad1 = 0;
    at61 = 8'h00;
    for (int h = 0; h < 512; h++) begin
      pxl_cen = 1'b1;
      hdump   = 9'(h);
      tick;
      if (pxl0 !== 8'h0F) bad0++;
      if (pxl1 !== 8'h0F) bad1++;
      if (h == 'h61) at61 = pxl0;
    end
    pxl_cen = 1'b0;
    tick;
  endtask

  task automatic wait_idle(input logic w, input int start, output int n);
    n = start;
    while ((w ? busy1 : busy0) && n < 200) begin
      tick;
      n++;
    end
  endtask

  task automatic applyStimulus(input int g);
    logic [7:0] v;
    for (int i = 0; i < vec.size(); i++) begin
      if (vec[i].grp == g) begin
        read_px(vec[i].wide, vec[i].h, v);
        checkOutput($sformatf("rd%0d_h%03h", g, vec[i].h), 32'(v), 32'(vec[i].exp));
      end
    end
  endtask

  // Guard against a hung simulation.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    int         n, b0, b1;
    logic [7:0] a61;

    for (int i = 0; i < 7; i++) add(1, 1'b0, 'h20 + i, 'h50 + i);
    add(1, 1'b0, 'h27, 'h0F);
    add(2, 1'b0, 'h20, 'h0F);
    for (int i = 0; i < 7; i++) add(2, 1'b0, 'h21 + i, 'h56 - i);
    add(3, 1'b1, 'h1FB, 'h0F);
    for (int i = 0; i < 15; i++) add(3, 1'b1, ('h1FC + i) & 'h1FF, 'hA0 + i);
    add(3, 1'b1, 'h00B, 'hA1);
    add(4, 1'b0, 'h60, 'h50);
    add(4, 1'b0, 'h66, 'h56);
    add(4, 1'b0, 'h67, 'h0F);
    add(4, 1'b0, 'h40, 'h51);
    add(4, 1'b0, 'h46, 'h51);
    add(4, 1'b0, 'h47, 'h0F);
    add(5, 1'b0, 'h80, 'h50);
    add(5, 1'b0, 'h81, 'h51);
    add(5, 1'b0, 'h82, 'h52);
    add(5, 1'b0, 'h84, 'h0F);
    add(5, 1'b0, 'h85, 'h0F);
    add(5, 1'b0, 'h86, 'h0F);
    add(6, 1'b0, 'h84, 'h0F);
    add(6, 1'b0, 'h85, 'h0F);
    add(6, 1'b0, 'hA0, 'h0F);
    add(6, 1'b0, 'hA1, 'h0F);

    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; hdump = '0;
    draw0 = 1'b0; draw1 = 1'b0; code = '0; xpos = '0; ysub = '0; pal = '0;
    hflip = 1'b0; vflip = 1'b0; rom_ok = 1'b1;
    rom_data0 = 32'h0; w0 = 32'h0; w1 = 32'h0;
    tick;
    tick;
    checkOutput("rst_busy", 32'(busy0), 32'h0);
    checkOutput("rst_cs", 32'(rom_cs0), 32'h0);
    checkOutput("rst_addr", 32'(rom_addr0), 32'h0);
    checkOutput("rst_pxl", 32'(pxl0), 32'h0);
    rst = 1'b0;
    tick;

    // Clear both banks of both instances.
    erase_pass(b0, b1, a61);
    swap_banks;
    erase_pass(b0, b1, a61);
    swap_banks;

    // Basic 8-px draw into bank 1.
    code = 10'h155; ysub = 4'h3; xpos = 9'h020; pal = 4'h5; rom_data0 = 32'h0123456F;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    checkOutput("basic_addr", 32'(rom_addr0), 32'h2AA6);
    checkOutput("basic_cs_c1", 32'(rom_cs0), 32'h1);
    tick;
    tick;
    checkOutput("basic_cs_c3", 32'(rom_cs0), 32'h0);
    wait_idle(1'b0, 3, n);
    checkOutput("basic_ticks", 32'(n), 32'd11);
    swap_banks;
    applyStimulus(1);

    // Flipped draw into bank 0.
    hflip = 1'b1; vflip = 1'b1;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    checkOutput("flip_addr", 32'(rom_addr0), 32'h2AB8);
    wait_idle(1'b0, 1, n);
    checkOutput("flip_ticks", 32'(n), 32'd11);
    swap_banks;
    applyStimulus(2);

    // 16-px object wrapping around the end of the line.
    hflip = 1'b0; vflip = 1'b0; code = 10'h0AA; ysub = 4'h0; xpos = 9'h1FC; pal = 4'hA;
    w0 = 32'h01234567; w1 = 32'h89ABCDE1;
    draw1 = 1'b1;
    tick;
    draw1 = 1'b0;
    checkOutput("wide_addr_w0", 32'(rom_addr1), 32'h1540);
    repeat (10) tick;
    checkOutput("wide_cs_c11", 32'(rom_cs1), 32'h1);
    checkOutput("wide_word_c11", 32'(rom_addr1[0]), 32'h1);
    wait_idle(1'b1, 11, n);
    checkOutput("wide_ticks", 32'(n), 32'd21);
    swap_banks;
    applyStimulus(3);

    // ROM stall: rom_ok low for five cycles after rom_cs rises.
    code = 10'h155; ysub = 4'h3; pal = 4'h5; xpos = 9'h060; rom_data0 = 32'h0123456F;
    rom_ok = 1'b0;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    repeat (4) tick;
    checkOutput("stall_cs_c5", 32'(rom_cs0), 32'h1);
    tick;
    rom_ok = 1'b1;
    wait_idle(1'b0, 6, n);
    checkOutput("stall_ticks", 32'(n), 32'd15);

    // Stale rom_ok in the guard cycle must not latch the wrong word.
    xpos = 9'h040; rom_data0 = 32'h77777777;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    tick;
    rom_ok = 1'b0; rom_data0 = 32'h1111111F;
    tick;
    rom_ok = 1'b1;
    wait_idle(1'b0, 3, n);
    checkOutput("guard_ticks", 32'(n), 32'd12);
    swap_banks;
    applyStimulus(4);

    // Abort: LHBL falls in cycle 6 of a draw.
    xpos = 9'h080; rom_data0 = 32'h0123456F;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    repeat (5) tick;
    LHBL = 1'b0;
    tick;
    LHBL = 1'b1;
    checkOutput("abort_busy", 32'(busy0), 32'h0);
    checkOutput("abort_cs", 32'(rom_cs0), 32'h0);
    repeat (10) tick;
    applyStimulus(5);

    // Draw in the same cycle as a swap is dropped.
    xpos = 9'h0A0;
    LHBL = 1'b0; draw0 = 1'b1;
    tick;
    LHBL = 1'b1; draw0 = 1'b0;
    checkOutput("drop_busy_c1", 32'(busy0), 32'h0);
    repeat (4) tick;
    checkOutput("drop_busy_c5", 32'(busy0), 32'h0);
    repeat (10) tick;
    applyStimulus(6);

    // Full line read twice: leftovers show in the first pass, the second is clean.
    erase_pass(b0, b1, a61);
    checkOutput("erase1_h061", 32'(a61), 32'h51);
    erase_pass(b0, b1, a61);
    checkOutput("erase2_bad", 32'(b0), 32'd0);
    checkOutput("erase2_bad_w", 32'(b1), 32'd0);

    // Reset in the middle of DRAW with sel=1 and a non-zero pixel output.
    swap_banks;
    xpos = 9'h0C0;
    draw0 = 1'b1;
    tick;
    draw0 = 1'b0;
    repeat (4) tick;
    rst = 1'b1;
    tick;
    checkOutput("mrst_busy", 32'(busy0), 32'h0);
    checkOutput("mrst_cs", 32'(rom_cs0), 32'h0);
    checkOutput("mrst_pxl", 32'(pxl0), 32'h0);
    checkOutput("mrst_sel", 32'(dut.sel), 32'h0);
    checkOutput("mrst_addr", 32'(rom_addr0), 32'h0);
    rst = 1'b0;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
